// File: rtl/store_monitor_pkg.sv
// Shared types for the store monitor: FSM states, failure codes and the store-log entry.
package monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    BAD_ADDR = 2'd1,
    BAD_DATA = 2'd2,
    TIMEOUT  = 2'd3
  } fail_code_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

endpackage

// File: rtl/store_monitor_if.sv
// Data-memory write bus as driven by the single-cycle core.
interface store_monitor_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;

  modport master (output MemWrite, output DataAdr, output WriteData);
  modport slave  (input  MemWrite, input  DataAdr, input  WriteData);
endinterface

// File: rtl/store_monitor_log_buf.sv
// Circular log of the most recent stores; overwrites the oldest entry on wrap, async read.
module store_log_buf
  import monitor_pkg::*;
#(
  parameter int unsigned LOG_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  log_entry_t                   wr_entry,
  output logic [$clog2(LOG_DEPTH)-1:0] wr_ptr,
  input  logic [$clog2(LOG_DEPTH)-1:0] rd_idx,
  output log_entry_t                   rd_entry
);

  localparam int unsigned IW = $clog2(LOG_DEPTH);

  log_entry_t mem [LOG_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
      wr_ptr      <= wr_ptr + IW'(1);
    end
  end

  // Read straight from the array: a same-cycle write to this slot is seen only after the edge.
  assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/store_monitor.sv
// Self-check stage: watches core stores and issues a sticky PASS/FAIL verdict with counters and a store log.
module store_monitor
  import monitor_pkg::state_e, monitor_pkg::fail_code_e, monitor_pkg::log_entry_t;
#(
  parameter logic [31:0] PASS_ADDR    = 32'd100,
  parameter logic [31:0] PASS_DATA    = 32'd7,
  parameter logic [31:0] ALLOWED_ADDR = 32'd96,
  parameter int unsigned TIMEOUT      = 1000,
  parameter int unsigned LOG_DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  store_monitor_if.slave               bus,
  input  logic [$clog2(LOG_DEPTH)-1:0] log_rd_idx,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic [1:0]                   fail_code,
  output logic [15:0]                  store_count,
  output logic [15:0]                  cycle_count,
  output logic [$clog2(LOG_DEPTH)-1:0] log_wr_ptr,
  output logic [31:0]                  log_rd_addr,
  output logic [31:0]                  log_rd_data
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e     state_q, state_d;
  fail_code_e code_q, code_d;
  logic       store_hit;
  log_entry_t wr_entry, rd_entry;

  assign store_hit = (state_q == monitor_pkg::RUN) && bus.MemWrite;

  // Store checks outrank the timeout, so a terminal store on the timeout edge decides the verdict.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      monitor_pkg::IDLE: state_d = monitor_pkg::RUN;
      monitor_pkg::RUN: begin
        if (store_hit && bus.DataAdr == PASS_ADDR && bus.WriteData == PASS_DATA) begin
          state_d = monitor_pkg::PASS;
        end else if (store_hit && bus.DataAdr == PASS_ADDR) begin
          state_d = monitor_pkg::FAIL;
          code_d  = monitor_pkg::BAD_DATA;
        end else if (store_hit && bus.DataAdr != ALLOWED_ADDR) begin
          state_d = monitor_pkg::FAIL;
          code_d  = monitor_pkg::BAD_ADDR;
        end else if (cycle_count == TO_LAST) begin
          state_d = monitor_pkg::FAIL;
          code_d  = monitor_pkg::TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= monitor_pkg::IDLE;
      code_q      <= monitor_pkg::NONE;
      store_count <= '0;
      cycle_count <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      if (state_q == monitor_pkg::RUN && cycle_count != '1) begin
        cycle_count <= cycle_count + 16'd1;
      end
      if (store_hit && store_count != '1) begin
        store_count <= store_count + 16'd1;
      end
    end
  end

  assign pass      = (state_q == monitor_pkg::PASS);
  assign fail      = (state_q == monitor_pkg::FAIL);
  assign done      = pass | fail;
  assign fail_code = code_q;

  assign wr_entry = '{addr: bus.DataAdr, data: bus.WriteData};

  store_log_buf #(
    .LOG_DEPTH(LOG_DEPTH)
  ) u_log (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (store_hit),
    .wr_entry (wr_entry),
    .wr_ptr   (log_wr_ptr),
    .rd_idx   (log_rd_idx),
    .rd_entry (rd_entry)
  );

  assign log_rd_addr = rd_entry.addr;
  assign log_rd_data = rd_entry.data;

endmodule

// File: tb/tb_store_monitor.sv
// Randomized and directed bench for store_monitor against a store-history reference model.
module tb_store_monitor;

  localparam int unsigned TO = 20;
  localparam int unsigned LD = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  log_rd_idx = '0;
  logic        done, pass, fail;
  logic [1:0]  fail_code;
  logic [15:0] store_count, cycle_count;
  logic [2:0]  log_wr_ptr;
  logic [31:0] log_rd_addr, log_rd_data;

  store_monitor_if bus ();

  store_monitor #(
    .PASS_ADDR    (32'd100),
    .PASS_DATA    (32'd7),
    .ALLOWED_ADDR (32'd96),
    .TIMEOUT      (TO),
    .LOG_DEPTH    (LD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .log_rd_idx  (log_rd_idx),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .fail_code   (fail_code),
    .store_count (store_count),
    .cycle_count (cycle_count),
    .log_wr_ptr  (log_wr_ptr),
    .log_rd_addr (log_rd_addr),
    .log_rd_data (log_rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 run, 2 pass, 3 fail; every logged store kept in history.
  int          m_phase, m_code, m_stores, m_cycles;
  logic [31:0] h_addr [$];
  logic [31:0] h_data [$];

  task automatic model_edge(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] d);
    int c;
    if (rst) begin
      m_phase = 0; m_code = 0; m_stores = 0; m_cycles = 0;
      h_addr.delete(); h_data.delete();
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      c = m_cycles;
      if (m_cycles < 65535) m_cycles++;
      if (we) begin
        if (m_stores < 65535) m_stores++;
        h_addr.push_back(a);
        h_data.push_back(d);
        if (a == 100 && d == 7) m_phase = 2;
        else if (a == 100) begin m_phase = 3; m_code = 2; end
        else if (a != 96) begin m_phase = 3; m_code = 1; end
      end
      if (m_phase == 1 && c == int'(TO) - 1) begin m_phase = 3; m_code = 3; end
    end
  endtask

  function automatic logic [63:0] exp_slot(input int s);
    logic [63:0] r = '0;
    for (int i = 0; i < h_addr.size(); i++)
      if (i % int'(LD) == s) r = {h_addr[i], h_data[i]};
    return r;
  endfunction

  task automatic compare_all();
    logic [63:0] e;
    e = exp_slot(int'(log_rd_idx));
    check("done",        32'(done),        32'(m_phase >= 2));
    check("pass",        32'(pass),        32'(m_phase == 2));
    check("fail",        32'(fail),        32'(m_phase == 3));
    check("fail_code",   32'(fail_code),   32'(m_code));
    check("store_count", 32'(store_count), 32'(m_stores));
    check("cycle_count", 32'(cycle_count), 32'(m_cycles));
    check("log_wr_ptr",  32'(log_wr_ptr),  32'(h_addr.size() % int'(LD)));
    check("log_rd_addr", log_rd_addr,      e[63:32]);
    check("log_rd_data", log_rd_data,      e[31:0]);
  endtask

  task automatic cycle(input bit we, input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite  = we;
    bus.DataAdr   = a;
    bus.WriteData = d;
    log_rd_idx    = 3'($urandom_range(0, 7));
    @(posedge clk);
    model_edge(reset, we, a, d);
    #1;
    compare_all();
  endtask

  // Reset for n cycles, then spend the IDLE cycle so the monitor is in RUN.
  task automatic start_run(input int n);
    reset = 1'b1;
    repeat (n) cycle(1'b0, '0, '0);
    reset = 1'b0;
    cycle(1'b0, '0, '0);
  endtask

  initial begin
    logic [31:0] a, d;
    int r;
    bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;

    // 1: success sequence
    reset = 1'b1;
    cycle(1'b0, '0, '0);
    cycle(1'b0, '0, '0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail_code", 32'(fail_code), 32'd0);
    reset = 1'b0;
    cycle(1'b1, 32'd100, 32'd7);   // ignored in IDLE
    cycle(1'b1, 32'd96, 32'd3);
    cycle(1'b1, 32'd96, 32'd4);
    check("t1_pass_early", 32'(pass), 32'd0);
    cycle(1'b1, 32'd100, 32'd7);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_store_count", 32'(store_count), 32'd3);
    check("t1_fail_code", 32'(fail_code), 32'd0);

    // 2: bad address, then absorbing
    start_run(2);
    cycle(1'b1, 32'd104, 32'd7);
    check("t2_fail", 32'(fail), 32'd1);
    check("t2_code", 32'(fail_code), 32'd1);
    cycle(1'b1, 32'd100, 32'd7);
    check("t2_still_fail", 32'(fail), 32'd1);
    check("t2_store_count", 32'(store_count), 32'd1);

    // 3: bad data
    start_run(1);
    cycle(1'b1, 32'd100, 32'd5);
    check("t3_fail", 32'(fail), 32'd1);
    check("t3_code", 32'(fail_code), 32'd2);
    check("t3_pass", 32'(pass), 32'd0);

    // 4: timeout, and a terminal store on the timeout edge
    start_run(1);
    repeat (TO - 1) cycle(1'b0, '0, '0);
    check("t4_no_fail_yet", 32'(fail), 32'd0);
    cycle(1'b0, '0, '0);
    check("t4_fail", 32'(fail), 32'd1);
    check("t4_code", 32'(fail_code), 32'd3);
    check("t4_cycles", 32'(cycle_count), 32'd20);
    start_run(1);
    repeat (TO - 1) cycle(1'b0, '0, '0);
    cycle(1'b1, 32'd100, 32'd7);
    check("t4b_pass", 32'(pass), 32'd1);
    check("t4b_fail", 32'(fail), 32'd0);

    // 5: log wrap
    start_run(1);
    for (int k = 0; k < 10; k++) cycle(1'b1, 32'd96, 32'(k));
    bus.MemWrite = 1'b1; bus.DataAdr = 32'd100; bus.WriteData = 32'd7;
    log_rd_idx = 3'd2;
    #1;
    check("t5_old_before_write", log_rd_data, 32'd2);
    @(posedge clk);
    model_edge(reset, 1'b1, 32'd100, 32'd7);
    #1;
    compare_all();
    check("t5_wr_ptr", 32'(log_wr_ptr), 32'd3);
    log_rd_idx = 3'd2;
    #1;
    check("t5_slot2_addr", log_rd_addr, 32'd100);
    check("t5_slot2_data", log_rd_data, 32'd7);
    log_rd_idx = 3'd1;
    #1;
    check("t5_slot1_addr", log_rd_addr, 32'd96);
    check("t5_slot1_data", log_rd_data, 32'd9);

    // 6: mid-run reset
    start_run(1);
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'd96, 32'(k + 20));
    reset = 1'b1;
    cycle(1'b0, '0, '0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_stores", 32'(store_count), 32'd0);
    check("t6_cycles", 32'(cycle_count), 32'd0);
    check("t6_ptr", 32'(log_wr_ptr), 32'd0);
    reset = 1'b0;
    cycle(1'b0, '0, '0);
    cycle(1'b1, 32'd96, 32'd1);
    cycle(1'b1, 32'd100, 32'd7);
    check("t6_pass", 32'(pass), 32'd1);
    check("t6_store_count", 32'(store_count), 32'd2);

    // Randomized runs, occasionally interrupted by reset
    for (int run = 0; run < 40; run++) begin
      reset = 1'b1;
      repeat (1 + $urandom_range(0, 1)) cycle(1'b0, '0, '0);
      reset = 1'b0;
      for (int c = 0; c < 26; c++) begin
        r = $urandom_range(0, 9);
        a = (r < 7) ? 32'd96 : (r < 9) ? 32'd100 : $urandom;
        d = ($urandom_range(0, 1) == 1) ? 32'd7 : 32'($urandom_range(0, 15));
        reset = ($urandom_range(0, 99) < 3);
        cycle($urandom_range(0, 2) != 0, a, d);
      end
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
